// File: rtl/caliptra_ss_tb_services_pkg.sv
// Shared definitions for the SoC BFM services request generator: command codes,
// the compact 2-bit command encoding carried through the FIFO, and FSM states.
package caliptra_ss_tb_services_pkg;

    localparam logic [7:0] CMD_ASSERT_RST        = 8'hF6;
    localparam logic [7:0] CMD_DEASSERT_RST      = 8'hF7;
    localparam logic [7:0] CMD_ASSERT_HARD_RST   = 8'hF8;
    localparam logic [7:0] CMD_DEASSERT_HARD_RST = 8'hF9;

    // Encoding doubles as the bit index into the flag/done vectors.
    typedef enum logic [1:0] {
        SVC_ASSERT_RST        = 2'd0,
        SVC_DEASSERT_RST      = 2'd1,
        SVC_ASSERT_HARD_RST   = 2'd2,
        SVC_DEASSERT_HARD_RST = 2'd3
    } tb_svc_cmd_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } tb_svc_state_e;

    function automatic logic cmd_known(input logic [7:0] code);
        return code inside {CMD_ASSERT_RST, CMD_DEASSERT_RST,
                            CMD_ASSERT_HARD_RST, CMD_DEASSERT_HARD_RST};
    endfunction

    function automatic tb_svc_cmd_e cmd_decode(input logic [7:0] code);
        tb_svc_cmd_e c;
        case (code)
            CMD_DEASSERT_RST:      c = SVC_DEASSERT_RST;
            CMD_ASSERT_HARD_RST:   c = SVC_ASSERT_HARD_RST;
            CMD_DEASSERT_HARD_RST: c = SVC_DEASSERT_HARD_RST;
            default:               c = SVC_ASSERT_RST;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/caliptra_ss_tb_cmd_fifo.sv
// Small synchronous FIFO of pending service commands. A push on a full FIFO is
// accepted only when a pop happens in the same cycle.
module caliptra_ss_tb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic          core_clk,
    input  logic          rst_b,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/caliptra_ss_tb_services_req_gen.sv
// Decodes firmware command bytes into one-hot BFM reset request flags and holds
// each flag until the matching done level (or a timeout) retires it.
module caliptra_ss_tb_services_req_gen
    import caliptra_ss_tb_services_pkg::*;
#(
    parameter int CMD_FIFO_DEPTH = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int MIN_GAP_CYCLES = 4
) (
    input  logic       core_clk,
    input  logic       rst_b,
    input  logic       cmd_wr_valid,
    input  logic [7:0] cmd_wr_data,
    output logic       assert_rst_flag,
    output logic       deassert_rst_flag,
    output logic       assert_hard_rst_flag,
    output logic       deassert_hard_rst_flag,
    input  logic       assert_rst_flag_done,
    input  logic       deassert_rst_flag_done,
    input  logic       assert_hard_rst_flag_done,
    input  logic       deassert_hard_rst_flag_done,
    output logic       busy,
    output logic       cmd_fifo_full,
    output logic       overflow_err,
    output logic       unknown_cmd_err,
    output logic       timeout_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam int GW = $clog2(MIN_GAP_CYCLES+1);
    localparam int CW = $clog2(CMD_FIFO_DEPTH+1);

    tb_svc_state_e state, state_d;
    tb_svc_cmd_e   cur_cmd, cur_d;
    logic [3:0]    flags, flags_d, done_vec;
    logic [TW-1:0] cnt, cnt_d;
    logic [GW-1:0] gap_cnt, gap_d;
    logic          pop, push, known, fifo_empty, timeout_set, cur_done;
    logic [1:0]    fifo_rd;
    logic [CW-1:0] fifo_count;

    assign done_vec = {deassert_hard_rst_flag_done, assert_hard_rst_flag_done,
                       deassert_rst_flag_done, assert_rst_flag_done};
    assign cur_done = done_vec[cur_cmd];
    assign known    = cmd_known(cmd_wr_data);
    assign push     = cmd_wr_valid & known;

    caliptra_ss_tb_cmd_fifo #(.DEPTH(CMD_FIFO_DEPTH), .W(2)) u_fifo (
        .core_clk (core_clk),
        .rst_b    (rst_b),
        .push     (push),
        .wr_data  (cmd_decode(cmd_wr_data)),
        .pop      (pop),
        .rd_data  (fifo_rd),
        .full     (cmd_fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        state_d     = state;
        cur_d       = cur_cmd;
        flags_d     = flags;
        cnt_d       = cnt;
        gap_d       = gap_cnt;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop     = 1'b1;
                cur_d   = tb_svc_cmd_e'(fifo_rd);
                state_d = ISSUE;
            end
            ISSUE: begin
                flags_d = 4'b0001 << cur_cmd;
                cnt_d   = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (cur_done) begin
                    flags_d = '0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (cnt == TW'(TIMEOUT_CYCLES-1)) begin
                    flags_d     = '0;
                    gap_d       = '0;
                    timeout_set = 1'b1;
                    state_d     = GAP;
                end else if (cnt != '1) begin
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP: begin
                // Wait for the BFM to drop its level ack so it cannot retire the next command.
                if (gap_cnt >= GW'(MIN_GAP_CYCLES-1) && !cur_done) state_d = IDLE;
                else if (gap_cnt != '1) gap_d = gap_cnt + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (!rst_b) begin
            state           <= IDLE;
            cur_cmd         <= SVC_ASSERT_RST;
            flags           <= '0;
            cnt             <= '0;
            gap_cnt         <= '0;
            overflow_err    <= 1'b0;
            unknown_cmd_err <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            state   <= state_d;
            cur_cmd <= cur_d;
            flags   <= flags_d;
            cnt     <= cnt_d;
            gap_cnt <= gap_d;
            if (push && cmd_fifo_full && !pop) overflow_err <= 1'b1;
            if (cmd_wr_valid && !known)        unknown_cmd_err <= 1'b1;
            if (timeout_set)                   timeout_err <= 1'b1;
        end
    end

    assign assert_rst_flag        = flags[0];
    assign deassert_rst_flag      = flags[1];
    assign assert_hard_rst_flag   = flags[2];
    assign deassert_hard_rst_flag = flags[3];
    assign busy = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_caliptra_ss_tb_services_req_gen.sv
// Directed bench for the BFM services request generator.
module tb_caliptra_ss_tb_services_req_gen;

    logic       core_clk = 1'b0;
    logic       rst_b;
    logic       cmd_wr_valid;
    logic [7:0] cmd_wr_data;
    logic [3:0] done_v;
    logic [3:0] flags;
    logic       busy, cmd_fifo_full, overflow_err, unknown_cmd_err, timeout_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 core_clk = ~core_clk;

    caliptra_ss_tb_services_req_gen #(
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (100),
        .MIN_GAP_CYCLES (4)
    ) dut (
        .core_clk                    (core_clk),
        .rst_b                       (rst_b),
        .cmd_wr_valid                (cmd_wr_valid),
        .cmd_wr_data                 (cmd_wr_data),
        .assert_rst_flag             (flags[0]),
        .deassert_rst_flag           (flags[1]),
        .assert_hard_rst_flag        (flags[2]),
        .deassert_hard_rst_flag      (flags[3]),
        .assert_rst_flag_done        (done_v[0]),
        .deassert_rst_flag_done      (done_v[1]),
        .assert_hard_rst_flag_done   (done_v[2]),
        .deassert_hard_rst_flag_done (done_v[3]),
        .busy                        (busy),
        .cmd_fifo_full               (cmd_fifo_full),
        .overflow_err                (overflow_err),
        .unknown_cmd_err             (unknown_cmd_err),
        .timeout_err                 (timeout_err)
    );

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic write_cmd(input logic [7:0] code);
        cmd_wr_valid = 1'b1;
        cmd_wr_data  = code;
        tick();
        cmd_wr_valid = 1'b0;
        cmd_wr_data  = 8'h00;
    endtask

    // Wait for a flag, check which one, ack it after a few cycles, drop the ack.
    task automatic serve(input string tag, input int idx, input bit chk_gap);
        int n = 0;
        while (flags == 4'b0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_flag"}, {28'b0, flags}, 32'(4'b0001 << idx));
        if (chk_gap) check({tag, "_gap_ok"}, 32'(n >= 4), 32'd1);
        repeat (3) tick();
        done_v[idx] = 1'b1;
        n = 0;
        while (flags != 4'b0 && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_retired"}, {28'b0, flags}, 32'd0);
        done_v[idx] = 1'b0;
    endtask

    initial begin
        int hi;
        int n;
        rst_b        = 1'b0;
        cmd_wr_valid = 1'b0;
        cmd_wr_data  = 8'h00;
        done_v       = 4'b0;
        repeat (2) tick();
        check("rst_flags", {28'b0, flags}, 32'd0);
        check("rst_status", {27'b0, busy, cmd_fifo_full, overflow_err, unknown_cmd_err, timeout_err}, 32'd0);
        rst_b = 1'b1;
        tick();

        // Single ASSERT_RST with ack 10 cycles after the flag rises
        write_cmd(8'hF6);                        // edge 0
        check("t1_busy_enq", {31'b0, busy}, 32'd1);
        tick();                                  // edge 1: pop
        check("t1_flag_c1", {28'b0, flags}, 32'd0);
        tick();                                  // edge 2: flag rises
        check("t1_flag_c2", {28'b0, flags}, 32'b0001);
        repeat (10) tick();                      // edge 12
        check("t1_flag_c12", {28'b0, flags}, 32'b0001);
        done_v[0] = 1'b1;
        tick();                                  // edge 13
        check("t1_flag_c13", {28'b0, flags}, 32'd0);
        repeat (6) tick();                       // ack still high: must stay in gap
        check("t1_busy_stale_done", {31'b0, busy}, 32'd1);
        done_v[0] = 1'b0;
        tick();
        check("t1_busy_idle", {31'b0, busy}, 32'd0);
        check("t1_errs", {29'b0, overflow_err, unknown_cmd_err, timeout_err}, 32'd0);

        // Burst: F8,F9,F6,F7,F7 fill the FIFO behind the first pop; last F6 is dropped
        write_cmd(8'hF8);
        write_cmd(8'hF9);
        write_cmd(8'hF6);
        write_cmd(8'hF7);
        write_cmd(8'hF7);
        check("t2_full", {31'b0, cmd_fifo_full}, 32'd1);
        check("t2_no_ovf_yet", {31'b0, overflow_err}, 32'd0);
        write_cmd(8'hF6);
        check("t2_overflow", {31'b0, overflow_err}, 32'd1);
        serve("t2_a", 2, 1'b0);
        serve("t2_b", 3, 1'b1);
        serve("t2_c", 0, 1'b1);
        serve("t2_d", 1, 1'b1);
        serve("t2_e", 1, 1'b1);
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        check("t2_idle", {31'b0, busy}, 32'd0);
        check("t2_no_extra", {28'b0, flags}, 32'd0);

        // Undefined code
        write_cmd(8'h42);
        check("t3_unknown", {31'b0, unknown_cmd_err}, 32'd1);
        check("t3_busy", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        check("t3_flags", {28'b0, flags}, 32'd0);

        // Timeout on DEASSERT_RST, then next command still served
        write_cmd(8'hF7);
        repeat (2) tick();
        hi = 0;
        while (flags[1] && hi < 300) begin hi++; tick(); end
        check("t4_high_cycles", 32'(hi), 32'd100);
        check("t4_timeout", {31'b0, timeout_err}, 32'd1);
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        check("t4_idle", {31'b0, busy}, 32'd0);
        write_cmd(8'hF6);
        serve("t4_next", 0, 1'b0);
        n = 0;
        while (busy && n < 30) begin tick(); n++; end

        // Wrong done during ASSERT_RST is ignored
        write_cmd(8'hF6);
        repeat (2) tick();
        done_v[2] = 1'b1;
        repeat (5) tick();
        check("t5_wrong_done", {28'b0, flags}, 32'b0001);
        done_v[0] = 1'b1;
        tick();
        check("t5_right_done", {28'b0, flags}, 32'd0);
        done_v = 4'b0;
        n = 0;
        while (busy && n < 30) begin tick(); n++; end
        check("t5_idle", {31'b0, busy}, 32'd0);

        // Reset mid WAIT_DONE clears flag, errors and FIFO
        write_cmd(8'hF8);
        write_cmd(8'hF9);
        tick();
        check("t6_pre_flag", {28'b0, flags}, 32'b0100);
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        check("t6_flags", {28'b0, flags}, 32'd0);
        check("t6_status", {27'b0, busy, cmd_fifo_full, overflow_err, unknown_cmd_err, timeout_err}, 32'd0);
        repeat (4) tick();
        check("t6_stays_idle", {27'b0, busy, flags}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
